// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared definitions for the second-generation LCD controller.
//   - 4-bit host opcodes (OP_WRITE .. OP_RECENTER); 4'hE and 4'hF are illegal
//   - controller state encoding (state_t)
package lcd_ctrl_pkg;

  localparam logic [3:0] OP_WRITE    = 4'h0;
  localparam logic [3:0] OP_UP       = 4'h1;
  localparam logic [3:0] OP_DOWN     = 4'h2;
  localparam logic [3:0] OP_LEFT     = 4'h3;
  localparam logic [3:0] OP_RIGHT    = 4'h4;
  localparam logic [3:0] OP_MAX      = 4'h5;
  localparam logic [3:0] OP_MIN      = 4'h6;
  localparam logic [3:0] OP_AVE      = 4'h7;
  localparam logic [3:0] OP_CCW      = 4'h8;
  localparam logic [3:0] OP_CW       = 4'h9;
  localparam logic [3:0] OP_MIRX     = 4'hA;
  localparam logic [3:0] OP_MIRY     = 4'hB;
  localparam logic [3:0] OP_INVERT   = 4'hC;
  localparam logic [3:0] OP_RECENTER = 4'hD;

  typedef enum logic [2:0] {
    ST_RST,
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu: combinational pixel operator for the 2x2 operating window.
//   p1..p4 : current window pixels (p1 top-left, p2 top-right,
//            p3 bottom-left, p4 bottom-right)
//   op     : opcode; MAX..INVERT transform the window, anything else
//            passes the pixels through unchanged
//   q1..q4 : new window pixels
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p4,
  input  logic [3:0]       op,
  output logic [PIX_W-1:0] q1,
  output logic [PIX_W-1:0] q2,
  output logic [PIX_W-1:0] q3,
  output logic [PIX_W-1:0] q4
);

  function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Floor of the four-pixel mean; the sum carries two guard bits so it
  // cannot overflow, and the quotient always fits back into PIX_W bits.
  function automatic logic [PIX_W-1:0] ave4(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c,
                                            input logic [PIX_W-1:0] d);
    logic [PIX_W+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return PIX_W'(sum >> 2);
  endfunction

  logic [PIX_W-1:0] wmax;
  logic [PIX_W-1:0] wmin;
  logic [PIX_W-1:0] wave;

  assign wmax = max2(max2(p1, p2), max2(p3, p4));
  assign wmin = min2(min2(p1, p2), min2(p3, p4));
  assign wave = ave4(p1, p2, p3, p4);

  always_comb begin
    q1 = p1;
    q2 = p2;
    q3 = p3;
    q4 = p4;
    case (op)
      OP_MAX: begin
        q1 = wmax; q2 = wmax; q3 = wmax; q4 = wmax;
      end
      OP_MIN: begin
        q1 = wmin; q2 = wmin; q3 = wmin; q4 = wmin;
      end
      OP_AVE: begin
        q1 = wave; q2 = wave; q3 = wave; q4 = wave;
      end
      OP_CCW: begin
        q1 = p2; q2 = p4; q3 = p1; q4 = p3;
      end
      OP_CW: begin
        q1 = p3; q2 = p1; q3 = p4; q4 = p2;
      end
      OP_MIRX: begin
        q1 = p3; q2 = p4; q3 = p1; q4 = p2;
      end
      OP_MIRY: begin
        q1 = p2; q2 = p1; q3 = p4; q4 = p3;
      end
      OP_INVERT: begin
        q1 = ~p1; q2 = ~p2; q3 = ~p3; q4 = ~p4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_gen2.sv
// lcd_ctrl_gen2: image display controller, second generation.
// Loads an IMG_W x IMG_H image from IROM into a frame buffer, applies host
// commands to a 2x2 window and dumps the buffer to IRAM on WRITE.
//   clk        : clock, rising edge
//   reset      : synchronous, active-low
//   cmd        : 4-bit opcode, sampled with cmd_valid while busy=0
//   cmd_valid  : command strobe
//   IROM_Q     : ROM data, one cycle after IROM_A/IROM_rd
//   IROM_rd    : ROM read enable
//   IROM_A     : ROM address
//   IRAM_valid : RAM write strobe
//   IRAM_D     : RAM write data
//   IRAM_A     : RAM write address
//   busy       : high while commands are not accepted
//   done       : one-cycle pulse after the last WRITE beat
module lcd_ctrl_gen2
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [PIX_W-1:0]  IROM_Q,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              IRAM_valid,
  output logic [PIX_W-1:0]  IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam int N     = IMG_W * IMG_H;
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ROW_W-1:0]  ROW_RST   = ROW_W'(IMG_H / 2);
  localparam logic [COL_W-1:0]  COL_RST   = COL_W'(IMG_W / 2);

  // Window moves saturate at 1 and at the last row/column: the window
  // always covers (pos-1, pos), so position 0 would fall off the image.
  function automatic logic [ROW_W-1:0] row_step(input logic [ROW_W-1:0] r,
                                                input logic dec);
    if (dec) return (r == ROW_W'(1)) ? r : r - ROW_W'(1);
    return (r == ROW_W'(IMG_H - 1)) ? r : r + ROW_W'(1);
  endfunction

  function automatic logic [COL_W-1:0] col_step(input logic [COL_W-1:0] c,
                                                input logic dec);
    if (dec) return (c == COL_W'(1)) ? c : c - COL_W'(1);
    return (c == COL_W'(IMG_W - 1)) ? c : c + COL_W'(1);
  endfunction

  state_t             state;
  logic [3:0]         op_r;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic               vld_p1;
  logic [ADDR_W-1:0]  rom_addr_p1;
  logic [PIX_W-1:0]   fbuf [N];

  logic [ROW_W-1:0]   row_m1;
  logic [COL_W-1:0]   col_m1;
  logic [ADDR_W-1:0]  a1, a2, a3, a4;
  logic [ADDR_W-1:0]  wr_next;
  logic [PIX_W-1:0]   n1, n2, n3, n4;
  logic               load_we;
  logic               exec_we;

  // Image dimensions are powers of two, so row*IMG_W+col is a concatenation.
  assign row_m1  = row - ROW_W'(1);
  assign col_m1  = col - COL_W'(1);
  assign a1      = {row_m1, col_m1};
  assign a2      = {row_m1, col};
  assign a3      = {row,    col_m1};
  assign a4      = {row,    col};
  assign wr_next = IRAM_A + ADDR_W'(1);

  lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
    .p1 (fbuf[a1]),
    .p2 (fbuf[a2]),
    .p3 (fbuf[a3]),
    .p4 (fbuf[a4]),
    .op (op_r),
    .q1 (n1),
    .q2 (n2),
    .q3 (n3),
    .q4 (n4)
  );

  assign load_we = reset && (state == ST_LOAD) && vld_p1;
  assign exec_we = reset && (state == ST_EXEC);

  // Frame buffer: data only, never cleared; LOAD overwrites every entry.
  always_ff @(posedge clk) begin
    if (load_we) fbuf[rom_addr_p1] <= IROM_Q;
    if (exec_we) begin
      fbuf[a1] <= n1;
      fbuf[a2] <= n2;
      fbuf[a3] <= n3;
      fbuf[a4] <= n4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RST;
      IROM_rd     <= 1'b0;
      IROM_A      <= '0;
      IRAM_valid  <= 1'b0;
      IRAM_D      <= '0;
      IRAM_A      <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      vld_p1      <= 1'b0;
      rom_addr_p1 <= '0;
      op_r        <= OP_WRITE;
      row         <= ROW_RST;
      col         <= COL_RST;
    end else begin
      done   <= 1'b0;
      vld_p1 <= 1'b0;
      case (state)
        ST_RST: begin
          state   <= ST_LOAD;
          IROM_rd <= 1'b1;
          IROM_A  <= '0;
        end
        ST_LOAD: begin
          if (IROM_rd) begin
            if (IROM_A == ADDR_LAST) IROM_rd <= 1'b0;
            else                     IROM_A  <= IROM_A + ADDR_W'(1);
          end
          // ROM read stage p1: IROM_Q belongs to rom_addr_p1 when vld_p1
          vld_p1      <= IROM_rd;
          rom_addr_p1 <= IROM_A;
          if (vld_p1 && (rom_addr_p1 == ADDR_LAST)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r <= cmd;
            busy <= 1'b1;
            if (cmd == OP_WRITE) begin
              state      <= ST_WRITE;
              IRAM_valid <= 1'b1;
              IRAM_A     <= ADDR_ZERO;
              IRAM_D     <= fbuf[ADDR_ZERO];
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          case (op_r)
            OP_UP:       row <= row_step(row, 1'b1);
            OP_DOWN:     row <= row_step(row, 1'b0);
            OP_LEFT:     col <= col_step(col, 1'b1);
            OP_RIGHT:    col <= col_step(col, 1'b0);
            OP_RECENTER: begin
              row <= ROW_RST;
              col <= COL_RST;
            end
            default: ;
          endcase
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_WRITE: begin
          if (IRAM_A == ADDR_LAST) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            IRAM_A <= wr_next;
            IRAM_D <= fbuf[wr_next];
          end
        end
        default: state <= ST_RST;
      endcase
    end
  end

endmodule
